packet_rr_arbiter: RTL and testbench

//  Packet-atomic round-robin arbiter that shares one downstream flit link among N_PORTS

---
 rtl/packet_rr_arbiter_if.sv | 34 +++
 rtl/packet_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_packet_rr_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_rr_arbiter_if.sv
// Flit-link bundle between the packet buffers, the arbiter and downstream.
// The master side is the arbiter; the slave side is buffers plus sink.
interface packet_rr_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int FLIT_W  = 32
);
  logic [N_PORTS-1:0]        req_ready;
  logic [N_PORTS*FLIT_W-1:0] req_flit;
  logic [N_PORTS-1:0]        req_next;
  logic [FLIT_W-1:0]         out_flit;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;

  modport master (
    input  req_ready,
    input  req_flit,
    input  out_ready,
    output req_next,
    output out_flit,
    output out_valid,
    output out_last
  );

  modport slave (
    output req_ready,
    output req_flit,
    output out_ready,
    input  req_next,
    input  out_flit,
    input  out_valid,
    input  out_last
  );
endinterface

// File: rtl/packet_rr_arbiter.sv
// Packet-atomic round-robin arbiter: one owner per 1- or 2-flit packet,
// with a watchdog that abandons an owner stalling mid-packet.
module packet_rr_arbiter #(
  parameter int N_PORTS = 4,
  parameter int FLIT_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int PTR_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  packet_rr_arbiter_if.master  bus,
  output logic [PTR_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 abort
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic               flit_idx;
  logic               pkt_two;
  logic [CNT_W-1:0]   stall_cnt;

  logic [N_PORTS-1:0] rot;
  logic               found;
  logic [PTR_W-1:0]   off;
  logic [PTR_W:0]     sum;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   nxt_ptr;
  logic [FLIT_W-1:0]  cur_flit;
  logic               cur_rdy;
  logic               send;
  logic               is_last;
  logic               xfer;

  // Rotate requests so bit 0 is rr_ptr; lowest set bit wins.
  always_comb begin
    rot   = N_PORTS'({bus.req_ready, bus.req_ready} >> rr_ptr);
    found = |rot;
    off   = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) off = PTR_W'(i);
    end
    sum  = {1'b0, rr_ptr} + {1'b0, off};
    pick = sum[PTR_W-1:0];
    if (sum >= (PTR_W+1)'(N_PORTS)) begin
      pick = PTR_W'(sum - (PTR_W+1)'(N_PORTS));
    end
  end

  always_comb begin
    cur_flit = '0;
    cur_rdy  = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_id == PTR_W'(i)) begin
        cur_flit = bus.req_flit[i*FLIT_W +: FLIT_W];
        cur_rdy  = bus.req_ready[i];
      end
    end
  end

  assign nxt_ptr = (grant_id == PTR_W'(N_PORTS - 1)) ?
                   '0 : grant_id + 1'b1;

  assign send          = (state == SEND);
  assign busy          = send;
  assign is_last       = flit_idx ? pkt_two : ~cur_flit[0];
  assign bus.out_valid = send & cur_rdy;
  assign bus.out_flit  = send ? cur_flit : '0;
  assign bus.out_last  = bus.out_valid & is_last;
  assign xfer          = bus.out_valid & bus.out_ready;

  always_comb begin
    bus.req_next = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      bus.req_next[i] = xfer && (grant_id == PTR_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      flit_idx  <= 1'b0;
      pkt_two   <= 1'b0;
      stall_cnt <= '0;
      abort     <= 1'b0;
    end else begin
      abort <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_id  <= pick;
            flit_idx  <= 1'b0;
            stall_cnt <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            stall_cnt <= '0;
            if (is_last) begin
              state  <= IDLE;
              rr_ptr <= nxt_ptr;
            end else begin
              flit_idx <= 1'b1;
              pkt_two  <= cur_flit[0];
            end
          end else if (!cur_rdy) begin
            // A header withdrawn before sending is not a stall.
            if (!flit_idx) begin
              state <= IDLE;
            end else if (stall_cnt == CNT_W'(TIMEOUT - 1)) begin
              abort     <= 1'b1;
              state     <= IDLE;
              rr_ptr    <= nxt_ptr;
              stall_cnt <= '0;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end else begin
            stall_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Bench for packet_rr_arbiter: a per-cycle vector table for plain
// round robin, buffer queues plus a transfer scoreboard for the rest.
module tb_packet_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 15;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  packet_rr_arbiter_if #(.N_PORTS(N), .FLIT_W(W)) bus ();

  logic [PW-1:0] grant_id;
  logic          busy;
  logic          abort;

  packet_rr_arbiter #(
    .N_PORTS(N),
    .FLIT_W (W),
    .TIMEOUT(TO),
    .PTR_W  (PW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .grant_id(grant_id),
    .busy    (busy),
    .abort   (abort)
  );

  typedef struct {
    logic [W-1:0]  flit;
    logic          last;
    logic [PW-1:0] port;
  } exp_t;

  typedef struct {
    logic [N-1:0]  rdy;
    logic          v;
    logic          b;
    logic [PW-1:0] g;
    logic          l;
    logic [N-1:0]  nx;
  } vec_t;

  exp_t         sb[$];
  logic [W-1:0] pq[N][$];
  logic [N-1:0] hold;
  logic         ordy;
  bit           model;
  int           npass  = 0;
  int           ntotal = 0;
  vec_t         vecs[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic expect_out(input string nm,
                            input logic v,
                            input logic b,
                            input logic [N-1:0] nx,
                            input logic ab);
    chk({nm, "_valid"}, bus.out_valid, v);
    chk({nm, "_busy"},  busy,          b);
    chk({nm, "_next"},  bus.req_next,  nx);
    chk({nm, "_abort"}, abort,         ab);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.out_ready = ordy;
    if (model) begin
      for (int i = 0; i < N; i++) begin
        bus.req_ready[i] = !hold[i] && (pq[i].size() > 0);
        bus.req_flit[i*W +: W] = (pq[i].size() > 0) ? pq[i][0] : '0;
      end
    end
    @(negedge clk);
    if (model) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_next[i] === 1'b1) void'(pq[i].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        ntotal++;
        $display("FAIL xfer_unexpected: got flit %0h expected none",
                 bus.out_flit);
      end else begin
        e = sb.pop_front();
        chk("xfer_flit",  bus.out_flit, e.flit);
        chk("xfer_last",  bus.out_last, e.last);
        chk("xfer_grant", grant_id,     e.port);
        chk("xfer_next",  bus.req_next, 32'(1) << e.port);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.req_ready = '0;
    bus.req_flit  = '0;
    bus.out_ready = 1'b1;
    ordy  = 1'b1;
    hold  = '0;
    model = 1'b0;
    rst   = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_out("rst", 1'b0, 1'b0, 4'h0, 1'b0);
    chk("rst_grant", grant_id,     0);
    chk("rst_flit",  bus.out_flit, 0);
    chk("rst_last",  bus.out_last, 0);

    // All four ready, 1-flit headers: grants 0,1,2,3,0 with bubbles.
    vecs[0] = '{4'hF, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0};
    vecs[1] = '{4'hF, 1'b1, 1'b1, 3'd0, 1'b1, 4'h1};
    vecs[2] = '{4'hF, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0};
    vecs[3] = '{4'hF, 1'b1, 1'b1, 3'd1, 1'b1, 4'h2};
    vecs[4] = '{4'hF, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0};
    vecs[5] = '{4'hF, 1'b1, 1'b1, 3'd2, 1'b1, 4'h4};
    vecs[6] = '{4'hF, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0};
    vecs[7] = '{4'hF, 1'b1, 1'b1, 3'd3, 1'b1, 4'h8};
    vecs[8] = '{4'hF, 1'b0, 1'b0, 3'd0, 1'b0, 4'h0};
    vecs[9] = '{4'hF, 1'b1, 1'b1, 3'd0, 1'b1, 4'h1};
    bus.req_flit = {32'hA000_0030, 32'hA000_0020,
                    32'hA000_0010, 32'hA000_0000};
    sb.push_back('{32'hA000_0000, 1'b1, 3'd0});
    sb.push_back('{32'hA000_0010, 1'b1, 3'd1});
    sb.push_back('{32'hA000_0020, 1'b1, 3'd2});
    sb.push_back('{32'hA000_0030, 1'b1, 3'd3});
    sb.push_back('{32'hA000_0000, 1'b1, 3'd0});
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.req_ready = vecs[k].rdy;
      bus.out_ready = 1'b1;
      @(negedge clk);
      expect_out($sformatf("rr%0d", k), vecs[k].v, vecs[k].b,
                 vecs[k].nx, 1'b0);
      chk($sformatf("rr%0d_last", k), bus.out_last, vecs[k].l);
      if (vecs[k].b) chk($sformatf("rr%0d_grant", k), grant_id, vecs[k].g);
      else chk($sformatf("rr%0d_flit", k), bus.out_flit, 0);
    end

    model = 1'b1;
    tick();
    expect_out("drain", 1'b0, 1'b0, 4'h0, 1'b0);

    // Port 2 alone, 2-flit packet.
    pq[2].push_back(32'h0000_A2C3);
    pq[2].push_back(32'h0000_1234);
    sb.push_back('{32'h0000_A2C3, 1'b0, 3'd2});
    sb.push_back('{32'h0000_1234, 1'b1, 3'd2});
    tick();
    expect_out("p2_arb", 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    expect_out("p2_hdr", 1'b1, 1'b1, 4'h4, 1'b0);
    chk("p2_hdr_last", bus.out_last, 1'b0);
    tick();
    expect_out("p2_body", 1'b1, 1'b1, 4'h4, 1'b0);
    chk("p2_body_last", bus.out_last, 1'b1);
    chk("p2_body_grant", grant_id, 2);
    tick();
    expect_out("p2_done", 1'b0, 1'b0, 4'h0, 1'b0);

    // Backpressure mid-packet on port 1 while port 3 waits.
    pq[1].push_back(32'h0000_B101);
    pq[1].push_back(32'h0000_B1B0);
    sb.push_back('{32'h0000_B101, 1'b0, 3'd1});
    sb.push_back('{32'h0000_B1B0, 1'b1, 3'd1});
    tick();
    tick();
    expect_out("bp_hdr", 1'b1, 1'b1, 4'h2, 1'b0);
    pq[3].push_back(32'h0000_C300);
    sb.push_back('{32'h0000_C300, 1'b1, 3'd3});
    ordy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_out($sformatf("bp%0d", k), 1'b1, 1'b1, 4'h0, 1'b0);
      chk($sformatf("bp%0d_flit", k), bus.out_flit, 32'h0000_B1B0);
      chk($sformatf("bp%0d_grant", k), grant_id, 1);
    end
    ordy = 1'b1;
    tick();
    expect_out("bp_body", 1'b1, 1'b1, 4'h2, 1'b0);
    tick();
    expect_out("bp_gap", 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    expect_out("bp_p3", 1'b1, 1'b1, 4'h8, 1'b0);
    tick();

    // Port 0 stalls after its header: watchdog hands over to port 1.
    pq[0].push_back(32'h0000_D001);
    pq[0].push_back(32'h0000_D0B0);
    pq[1].push_back(32'h0000_E100);
    sb.push_back('{32'h0000_D001, 1'b0, 3'd0});
    sb.push_back('{32'h0000_E100, 1'b1, 3'd1});
    tick();
    tick();
    expect_out("wd_hdr", 1'b1, 1'b1, 4'h1, 1'b0);
    hold[0] = 1'b1;
    for (int k = 0; k < TO; k++) begin
      tick();
      expect_out($sformatf("wd_stall%0d", k), 1'b0, 1'b1, 4'h0, 1'b0);
    end
    tick();
    expect_out("wd_abort", 1'b0, 1'b0, 4'h0, 1'b1);
    pq[0].delete();
    hold[0] = 1'b0;
    tick();
    expect_out("wd_next", 1'b1, 1'b1, 4'h2, 1'b0);
    tick();
    expect_out("wd_idle", 1'b0, 1'b0, 4'h0, 1'b0);

    // Reset during the body of port 3's packet.
    pq[3].push_back(32'h0000_F301);
    pq[3].push_back(32'h0000_F3B0);
    pq[1].push_back(32'h0000_F100);
    sb.push_back('{32'h0000_F301, 1'b0, 3'd3});
    tick();
    tick();
    expect_out("rs_hdr", 1'b1, 1'b1, 4'h8, 1'b0);
    ordy = 1'b0;
    tick();
    expect_out("rs_body", 1'b1, 1'b1, 4'h0, 1'b0);
    rst = 1'b1;
    pq[3].delete();
    pq[3].push_back(32'h0000_F310);
    sb.push_back('{32'h0000_F100, 1'b1, 3'd1});
    sb.push_back('{32'h0000_F310, 1'b1, 3'd3});
    tick();
    expect_out("rs_cut", 1'b0, 1'b0, 4'h0, 1'b0);
    chk("rs_cut_grant", grant_id,     0);
    chk("rs_cut_flit",  bus.out_flit, 0);
    chk("rs_cut_last",  bus.out_last, 0);
    rst  = 1'b0;
    ordy = 1'b1;
    tick();
    expect_out("rs_first", 1'b1, 1'b1, 4'h2, 1'b0);
    tick();
    tick();
    expect_out("rs_second", 1'b1, 1'b1, 4'h8, 1'b0);
    tick();
    expect_out("rs_idle", 1'b0, 1'b0, 4'h0, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
